// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: state codes and default constants for the HC-SR04 sequencer.
// Revision 1.0
`default_nettype none

package hcsr04_pkg;

   localparam int ESTADO_W = 4;

   localparam logic [ESTADO_W-1:0] S_INICIAL          = 4'd0;
   localparam logic [ESTADO_W-1:0] S_ARBITRA          = 4'd1;
   localparam logic [ESTADO_W-1:0] S_PREPARACAO       = 4'd2;
   localparam logic [ESTADO_W-1:0] S_ENVIA_TRIGGER    = 4'd3;
   localparam logic [ESTADO_W-1:0] S_ESPERA_ECO       = 4'd4;
   localparam logic [ESTADO_W-1:0] S_ARMAZENA         = 4'd5;
   localparam logic [ESTADO_W-1:0] S_FINAL_OK         = 4'd6;
   localparam logic [ESTADO_W-1:0] S_TENTATIVA        = 4'd7;
   localparam logic [ESTADO_W-1:0] S_FINAL_ERRO       = 4'd8;
   localparam logic [ESTADO_W-1:0] S_LIBERA           = 4'd9;
   localparam logic [ESTADO_W-1:0] S_ESPERA_INTERVALO = 4'd10;

   localparam int INTERVALO_DEF = 3_000_000;
   localparam int MAX_TENT_DEF  = 3;

endpackage

`default_nettype wire

// File: rtl/arbitro_rr.sv
// arbitro_rr: one-hot round-robin pick with a pointer updated on a strobe.
// Revision 1.0
`default_nettype none

module arbitro_rr #(
   parameter int NREQ = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] grant,
   input  logic            atualiza,
   output logic [NREQ-1:0] escolha
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] idx;
   logic [PW-1:0] j;
   logic          achou;

   // Search starts just above the last served requester, wrapping around.
   always_comb begin
      escolha = '0;
      achou   = 1'b0;
      j       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = PW'((int'(ptr) + k) % NREQ);
         if (!achou && req[j]) begin
            escolha[j] = 1'b1;
            achou      = 1'b1;
         end
      end
   end

   always_comb begin
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) idx = PW'(i);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr <= PW'(NREQ - 1);
      end else if (atualiza) begin
         ptr <= idx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/hcsr04_sequenciador_uc.sv
// hcsr04_sequenciador_uc: shares one HC-SR04 datapath among NREQ requesters with retries.
// Optional inter-trigger cooldown via HCSR04_COOLDOWN_EN. Revision 1.0
`default_nettype none

module hcsr04_sequenciador_uc
   import hcsr04_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int MAX_TENT  = MAX_TENT_DEF,
   parameter int INTERVALO = INTERVALO_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NREQ-1:0]     medir_req,
   output logic [NREQ-1:0]     grant,
   output logic                pronto,
   output logic                erro,
   output logic                fd_zera,
   output logic                fd_gera,
   output logic                fd_zera_timeout,
   output logic                fd_conta_timeout,
   output logic                fd_registra,
   input  logic                fd_fim_medida,
   input  logic                fd_timeout,
   output logic [ESTADO_W-1:0] db_estado
);

   if (NREQ < 2 || NREQ > 4 || MAX_TENT < 1 || MAX_TENT > 7 || INTERVALO < 1) begin : g_param_check
      $error("hcsr04_sequenciador_uc: parameter out of range");
   end

   logic [ESTADO_W-1:0] estado;
   logic [ESTADO_W-1:0] prox;
   logic [2:0]          tent;
   logic [2:0]          tent_inc;
   logic                ultima_tent;
   logic [NREQ-1:0]     escolha;
   logic                atualiza_ptr;

   assign tent_inc     = tent + 3'd1;
   assign ultima_tent  = (tent_inc == 3'(MAX_TENT));
   assign atualiza_ptr = (estado == S_FINAL_OK) || (estado == S_FINAL_ERRO);

   arbitro_rr #(
      .NREQ(NREQ)
   ) u_arbitro (
      .clock   (clock),
      .reset   (reset),
      .req     (medir_req),
      .grant   (grant),
      .atualiza(atualiza_ptr),
      .escolha (escolha)
   );

`ifdef HCSR04_COOLDOWN_EN
   localparam int CW = $clog2(INTERVALO + 1);
   localparam logic [CW-1:0] CD_LIM = CW'(INTERVALO - 1);

   logic [CW-1:0] cd;
   logic          cd_fim;

   assign cd_fim = (cd == CD_LIM);

   // Free-runs from each trigger and saturates at the limit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cd <= '0;
      end else if (estado == S_ENVIA_TRIGGER) begin
         cd <= '0;
      end else if (!cd_fim) begin
         cd <= cd + 1'b1;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= S_INICIAL;
      end else begin
         estado <= prox;
      end
   end

   always_comb begin
      prox = estado;
      case (estado)
         S_INICIAL:       prox = S_ARBITRA;
         S_ARBITRA:       prox = (|medir_req) ? S_PREPARACAO : S_ARBITRA;
         S_PREPARACAO:    prox = S_ENVIA_TRIGGER;
         S_ENVIA_TRIGGER: prox = S_ESPERA_ECO;
         S_ESPERA_ECO: begin
            if (fd_fim_medida)   prox = S_ARMAZENA;
            else if (fd_timeout) prox = S_TENTATIVA;
         end
         S_ARMAZENA:      prox = S_FINAL_OK;
         S_FINAL_OK:      prox = S_LIBERA;
`ifdef HCSR04_COOLDOWN_EN
         S_TENTATIVA:     prox = ultima_tent ? S_FINAL_ERRO : S_ESPERA_INTERVALO;
         S_FINAL_ERRO:    prox = S_LIBERA;
         S_LIBERA:        prox = S_ESPERA_INTERVALO;
         // A non-zero attempt count means we came from a retry, not from libera.
         S_ESPERA_INTERVALO: begin
            if (cd_fim) prox = (tent != 3'd0) ? S_PREPARACAO : S_INICIAL;
         end
`else
         S_TENTATIVA:     prox = ultima_tent ? S_FINAL_ERRO : S_PREPARACAO;
         S_FINAL_ERRO:    prox = S_LIBERA;
         S_LIBERA:        prox = S_INICIAL;
`endif
         default:         prox = S_INICIAL;
      endcase
   end

   always_comb begin
      pronto           = 1'b0;
      erro             = 1'b0;
      fd_zera          = 1'b0;
      fd_gera          = 1'b0;
      fd_zera_timeout  = 1'b0;
      fd_conta_timeout = 1'b0;
      fd_registra      = 1'b0;
      case (estado)
         S_PREPARACAO: begin
            fd_zera         = 1'b1;
            fd_zera_timeout = 1'b1;
         end
         S_ENVIA_TRIGGER: fd_gera          = 1'b1;
         S_ESPERA_ECO:    fd_conta_timeout = 1'b1;
         S_ARMAZENA:      fd_registra      = 1'b1;
         S_FINAL_OK:      pronto           = 1'b1;
         S_FINAL_ERRO:    erro             = 1'b1;
         default: ;
      endcase
   end

   assign db_estado = estado;

   // grant is held through libera and dropped on the way back to inicial.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant <= '0;
         tent  <= 3'd0;
      end else begin
         case (estado)
            S_ARBITRA: begin
               if (|medir_req) grant <= escolha;
            end
            S_TENTATIVA: tent <= tent_inc;
            S_LIBERA: begin
               grant <= '0;
               tent  <= 3'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hcsr04_sequenciador_uc.sv
// tb_hcsr04_sequenciador_uc: scoreboard bench for the HC-SR04 sequencer.
// Revision 1.0
`default_nettype none

module tb_hcsr04_sequenciador_uc;

   localparam int NREQ      = 2;
   localparam int MAX_TENT  = 3;
   localparam int INTERVALO = 1000;
   localparam int D         = 200;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [NREQ-1:0] medir_req = '0;
   logic [NREQ-1:0] grant;
   logic            pronto, erro;
   logic            fd_zera, fd_gera, fd_zera_timeout, fd_conta_timeout, fd_registra;
   logic            fd_fim_medida = 1'b0;
   logic            fd_timeout = 1'b0;
   logic [3:0]      db_estado;

   hcsr04_sequenciador_uc #(
      .NREQ(NREQ), .MAX_TENT(MAX_TENT), .INTERVALO(INTERVALO)
   ) dut (
      .clock(clock), .reset(reset), .medir_req(medir_req), .grant(grant),
      .pronto(pronto), .erro(erro), .fd_zera(fd_zera), .fd_gera(fd_gera),
      .fd_zera_timeout(fd_zera_timeout), .fd_conta_timeout(fd_conta_timeout),
      .fd_registra(fd_registra), .fd_fim_medida(fd_fim_medida),
      .fd_timeout(fd_timeout), .db_estado(db_estado)
   );

   always #10 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [NREQ-1:0] g;
      bit              ok;
      int              tries;
   } exp_t;

   exp_t sb[$];
   int   gera_t[$];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Sensor model: echo and/or timeout fire D cycles after each trigger.
   int mode = 0;
   int gera_cyc = -100000;
   always @(negedge clock) begin
      if (fd_gera) gera_cyc = cyc;
      fd_fim_medida = (mode == 1 || mode == 3) && (cyc == gera_cyc + D);
      fd_timeout    = (mode == 2 || mode == 3) && (cyc == gera_cyc + D);
   end

   int   n_zera = 0, n_gera = 0, n_reg = 0, n_zt = 0, n_ct = 0;
   int   order_bad = 0, post = 0, done_cnt = 0;
   bit   prev_gera = 1'b0;
   logic [NREQ-1:0] last_g = '0;
   exp_t e;

   always @(negedge clock) begin
      if (reset) begin
         if (fd_zera) n_zera++;
         if (fd_zera_timeout) n_zt++;
         if (fd_conta_timeout) n_ct++;
         if (fd_gera) begin
            n_gera++;
            if (!prev_gera) gera_t.push_back(cyc);
         end
         if (fd_registra) begin
            n_reg++;
            if (n_gera == 0) order_bad++;
         end
         prev_gera = fd_gera;
         if (post == 2) begin
            chk("grant_hold", 32'(grant), 32'(last_g));
            chk("st_libera", 32'(db_estado), 32'd9);
            post = 1;
         end else if (post == 1) begin
            chk("grant_clr", 32'(grant), 32'd0);
            post = 0;
         end
         if (pronto || erro) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("grant", 32'(grant), 32'(e.g));
               chk("kind", {30'd0, pronto, erro}, e.ok ? 32'd2 : 32'd1);
               chk("n_gera", 32'(n_gera), 32'(e.tries));
               chk("n_zera", 32'(n_zera), 32'(e.tries));
               chk("n_zera_to", 32'(n_zt), 32'(e.tries));
               chk("n_conta_to", 32'(n_ct), 32'(e.tries * D));
               chk("n_registra", 32'(n_reg), e.ok ? 32'd1 : 32'd0);
               chk("order", 32'(order_bad), 32'd0);
            end
            n_zera = 0; n_gera = 0; n_reg = 0; n_zt = 0; n_ct = 0; order_bad = 0;
            last_g = grant;
            post = 2;
            done_cnt++;
         end
      end
   end

   task automatic push_exp(input logic [NREQ-1:0] g, input bit ok, input int tries);
      exp_t x;
      x.g = g; x.ok = ok; x.tries = tries;
      sb.push_back(x);
   endtask

   task automatic run_req(input logic [NREQ-1:0] r, input int m, input int n);
      int target;
      int k;
      target = done_cnt + n;
      k = 0;
      mode = m;
      medir_req = r;
      while (done_cnt < target && k < 20000) begin
         @(posedge clock); #1;
         k++;
      end
      if (done_cnt < target) chk("wait_done", 32'(done_cnt), 32'(target));
      medir_req = '0;
      repeat (5) @(posedge clock);
      #1;
   endtask

   task automatic check_gaps(input string tag, input int n, input int gap);
      chk({tag, "_count"}, 32'(gera_t.size()), 32'(n));
      for (int i = 1; i < gera_t.size(); i++) begin
`ifdef HCSR04_COOLDOWN_EN
         chk({tag, "_gap_min"}, 32'(gera_t[i] - gera_t[i-1] >= INTERVALO), 32'd1);
`else
         chk({tag, "_gap"}, 32'(gera_t[i] - gera_t[i-1]), 32'(gap));
`endif
      end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_pronto", 32'(pronto), 32'd0);
      chk("rst_erro", 32'(erro), 32'd0);
      chk("rst_fd", {27'd0, fd_zera, fd_gera, fd_zera_timeout, fd_conta_timeout, fd_registra}, 32'd0);
      chk("rst_estado", 32'(db_estado), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("idle_arbitra", 32'(db_estado), 32'd1);

      // Single request, echo after D cycles.
      push_exp(2'b01, 1'b1, 1);
      run_req(2'b01, 1, 1);

      // Requester 1, every attempt times out.
      gera_t.delete();
      push_exp(2'b10, 1'b0, MAX_TENT);
      run_req(2'b10, 2, 1);
      check_gaps("retry", MAX_TENT, D + 3);

      // Both requesting, served alternately.
      gera_t.delete();
      push_exp(2'b01, 1'b1, 1);
      push_exp(2'b10, 1'b1, 1);
      push_exp(2'b01, 1'b1, 1);
      run_req(2'b11, 1, 3);
      check_gaps("b2b", 3, D + 7);

      // Echo and timeout in the same cycle: echo wins, no retry.
      push_exp(2'b01, 1'b1, 1);
      run_req(2'b01, 3, 1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
